i2c_byte_master: RTL and testbench



---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_byte_master.sv | 174 +++++++++++++++++
 tb/tb_i2c_byte_master.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding, phase constants and byte width shared by the I2C byte master
package i2c_pkg;

    localparam int I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_RESP
    } i2c_state_e;

    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;
    localparam logic [1:0] PH_3 = 2'd3;

endpackage

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: tick-driven byte-level I2C master; define I2C_CLK_STRETCH_EN to honour slave clock stretching
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter int TICK_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic                  cmd_read,
    input  logic [I2C_BYTE_W-1:0] cmd_wdata,
    input  logic                  cmd_mack,
    output logic                  rsp_valid,
    output logic [I2C_BYTE_W-1:0] rsp_rdata,
    output logic                  rsp_nack,
    output logic                  busy,
    output logic                  scl_oe,
    output logic                  sda_oe,
    input  logic                  scl_in,
    input  logic                  sda_in
);

    if (TICK_PER_BIT != 4) begin : g_bad_tick
        $error("i2c_byte_master: TICK_PER_BIT must be 4");
    end

    i2c_state_e            r_state;
    logic [1:0]            r_ph;
    logic [2:0]            r_bit;
    logic [I2C_BYTE_W-1:0] r_wdata;
    logic [I2C_BYTE_W-1:0] r_shift;
    logic                  r_read;
    logic                  r_stop;
    logic                  r_mack;
    logic                  r_nack;
    logic                  r_bus_owned;
    logic                  r_scl_oe;
    logic                  r_sda_oe;
    logic                  r_cmd_ready;
    logic                  r_busy;
    logic                  r_rsp_valid;
    logic [I2C_BYTE_W-1:0] r_rsp_rdata;
    logic                  r_rsp_nack;
    logic                  w_adv;

`ifdef I2C_CLK_STRETCH_EN
    // a slave holding SCL low while we have released it (ph2 of a data/ack bit) freezes the phase
    assign w_adv = tick && !((r_state == S_BIT || r_state == S_ACK) && r_ph == PH_2 && !scl_in);
`else
    logic w_unused;
    assign w_adv    = tick;
    assign w_unused = scl_in;
`endif

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_nack  = r_rsp_nack;
    assign busy      = r_busy;
    assign scl_oe    = r_scl_oe;
    assign sda_oe    = r_sda_oe;

    // protocol FSM: each tick closes the current phase and registers the line drive of the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ph        <= PH_0;
            r_bit       <= '0;
            r_wdata     <= '0;
            r_shift     <= '0;
            r_read      <= 1'b0;
            r_stop      <= 1'b0;
            r_mack      <= 1'b0;
            r_nack      <= 1'b0;
            r_bus_owned <= 1'b0;
            r_scl_oe    <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_nack  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_scl_oe <= r_bus_owned;
                    r_sda_oe <= 1'b0;
                    if (cmd_valid && r_cmd_ready) begin
                        r_wdata     <= cmd_wdata;
                        r_read      <= cmd_read;
                        r_stop      <= cmd_stop;
                        r_mack      <= cmd_mack;
                        r_ph        <= PH_0;
                        r_bit       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (cmd_start || !r_bus_owned) begin
                            r_state <= S_START;
                        end else begin
                            r_state  <= S_BIT;
                            r_scl_oe <= 1'b1;
                            r_sda_oe <= !cmd_read && !cmd_wdata[I2C_BYTE_W-1];
                        end
                    end
                end
                S_START: if (w_adv) begin
                    r_ph <= r_ph + 2'd1;
                    if (r_ph == PH_0) begin
                        r_scl_oe <= 1'b0;
                    end else if (r_ph == PH_1) begin
                        r_sda_oe <= 1'b1;
                    end else if (r_ph == PH_2) begin
                        r_scl_oe    <= 1'b1;
                        r_bus_owned <= 1'b1;
                    end else begin
                        r_state  <= S_BIT;
                        r_sda_oe <= !r_read && !r_wdata[I2C_BYTE_W-1];
                    end
                end
                S_BIT: if (w_adv) begin
                    r_ph <= r_ph + 2'd1;
                    if (r_ph == PH_1) r_scl_oe <= 1'b0;
                    if (r_ph == PH_2 && r_read) r_shift <= {r_shift[I2C_BYTE_W-2:0], sda_in};
                    if (r_ph == PH_3) begin
                        r_scl_oe <= 1'b1;
                        r_bit    <= r_bit + 3'd1;
                        r_wdata  <= r_wdata << 1;
                        r_state  <= (r_bit == 3'd7) ? S_ACK : S_BIT;
                        r_sda_oe <= (r_bit == 3'd7) ? (r_read && r_mack) : (!r_read && !r_wdata[I2C_BYTE_W-2]);
                    end
                end
                S_ACK: if (w_adv) begin
                    r_ph <= r_ph + 2'd1;
                    if (r_ph == PH_1) r_scl_oe <= 1'b0;
                    if (r_ph == PH_2) r_nack <= r_read ? !r_mack : sda_in;
                    if (r_ph == PH_3) begin
                        r_scl_oe <= 1'b1;
                        r_sda_oe <= r_stop;
                        r_state  <= r_stop ? S_STOP : S_RESP;
                        if (!r_stop) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_nack  <= r_nack;
                            if (r_read) r_rsp_rdata <= r_shift;
                        end
                    end
                end
                S_STOP: if (w_adv) begin
                    r_ph <= r_ph + 2'd1;
                    if (r_ph == PH_0) r_scl_oe <= 1'b0;
                    if (r_ph == PH_2) r_sda_oe <= 1'b0;
                    if (r_ph == PH_3) begin
                        r_state     <= S_RESP;
                        r_bus_owned <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_nack  <= r_nack;
                        if (r_read) r_rsp_rdata <= r_shift;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= r_bus_owned;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: scoreboard bench with a bus-level slave model for i2c_byte_master (stretch case under I2C_CLK_STRETCH_EN)
module tb_i2c_byte_master;

    typedef struct {
        logic [7:0] pat;
        logic       rd;
        logic [7:0] rdata;
        logic       nack;
        int         ticks;
    } exp_t;

    localparam logic [1:0] M_ACK  = 2'd0;
    localparam logic [1:0] M_NACK = 2'd1;
    localparam logic [1:0] M_READ = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    logic       cmd_read = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_mack = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    int         total = 0;
    int         bad = 0;
    int         rsp_seen = 0;
    int         tcount = 0;
    exp_t       exp_q[$];

    logic [1:0] tdiv = 2'd0;
    logic [1:0] s_mode = M_ACK;
    logic [7:0] s_byte = 8'h00;
    logic [3:0] s_cnt = 4'd9;
    logic [7:0] s_cap = 8'h00;
    logic       s_pull = 1'b0;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       arm_tgl = 1'b0;
    logic       arm_seen = 1'b0;
    logic       stretch_req = 1'b0;
    logic       st_hold = 1'b0;
    logic       st_done = 1'b0;
    int         st_n = 0;

    i2c_byte_master dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_stop  (cmd_stop),
        .cmd_read  (cmd_read),
        .cmd_wdata (cmd_wdata),
        .cmd_mack  (cmd_mack),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_in),
        .sda_in    (sda_in)
    );

    always #5 clk = ~clk;

    assign tick   = (tdiv == 2'd3);
    assign scl_in = !scl_oe && !st_hold;
    assign sda_in = !sda_oe && !s_pull;

    always @(posedge clk) tdiv <= tdiv + 2'd1;

    // ticks counted after the accepting edge, up to and including the final protocol tick
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) tcount <= 0;
        else if (tick) tcount <= tcount + 1;
    end

    // slave: tracks START and SCL rising edges, captures the wire byte, drives read data or ACK
    always @(negedge clk) begin
        if (arm_tgl != arm_seen) begin
            arm_seen <= arm_tgl;
            s_cnt    <= 4'd0;
        end else if (p_scl && scl_in && p_sda && !sda_in) begin
            s_cnt <= 4'd0;
        end else if (!p_scl && scl_in && s_cnt < 4'd9) begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt < 4'd8) s_cap <= {s_cap[6:0], sda_in};
        end
        p_scl <= scl_in;
        p_sda <= sda_in;
        if (!scl_in) s_pull <= (s_cnt < 4'd8) ? (s_mode == M_READ && !s_byte[3'(7 - s_cnt)])
                                              : (s_cnt == 4'd8 && s_mode == M_ACK);
    end

    // stretch: hold SCL low through the released half of bit 2 for exactly 10 ticks
    always @(posedge clk) begin
        if (stretch_req && !st_done) begin
            if (!st_hold) begin
                if (s_cnt == 4'd2 && scl_oe) st_hold <= 1'b1;
            end else if (tick && !scl_oe) begin
                st_n <= st_n + 1;
                if (st_n == 9) begin
                    st_hold <= 1'b0;
                    st_done <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] pat, input logic rd, input logic [7:0] rdata,
                                input logic nack, input int ticks);
        exp_t e;
        e.pat = pat;
        e.rd = rd;
        e.rdata = rdata;
        e.nack = nack;
        e.ticks = ticks;
        return e;
    endfunction

    // monitor: pops the scoreboard on every response and checks the one-cycle handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: rsp_valid with empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_nack", 32'(rsp_nack), 32'(e.nack));
                    chk("rsp_ticks", tcount, e.ticks);
                    chk("wire_byte", 32'(s_cap), 32'(e.pat));
                    if (e.rd) chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    chk("ready_at_rsp", 32'(cmd_ready), 0);
                    @(negedge clk);
                    chk("rsp_pulse", 32'(rsp_valid), 0);
                    chk("ready_after", 32'(cmd_ready), 1);
                end
                rsp_seen++;
            end
        end
    end

    task automatic issue(input logic st, input logic sp, input logic rd, input logic [7:0] wd,
                         input logic mk_ack, input logic [1:0] mode, input logic [7:0] sb,
                         input logic push, input exp_t e);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!cmd_ready) begin
            bad++;
            $display("FAIL issue_ready: cmd_ready got 0 expected 1 after %0d cycles", n);
        end
        s_mode    = mode;
        s_byte    = sb;
        arm_tgl   = ~arm_tgl;
        cmd_start = st;
        cmd_stop  = sp;
        cmd_read  = rd;
        cmd_wdata = wd;
        cmd_mack  = mk_ack;
        cmd_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string nm);
        int n0;
        int n;
        n0 = rsp_seen;
        n = 0;
        while (rsp_seen == n0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rsp_seen == n0) begin
            bad++;
            $display("FAIL %s: no rsp_valid within %0d cycles", nm, n);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        exp_t none;
        int n;
        none = mk(8'h00, 1'b0, 8'h00, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("rst_scl_oe", 32'(scl_oe), 0);
        chk("rst_sda_oe", 32'(sda_oe), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_nack", 32'(rsp_nack), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, M_ACK, 8'h00, 1'b1, mk(8'hA5, 1'b0, 8'h00, 1'b0, 44));
        wait_rsp("wr_a5");
        chk("a5_scl_released", 32'(scl_oe), 0);
        chk("a5_sda_released", 32'(sda_oe), 0);
        chk("a5_busy", 32'(busy), 0);

        issue(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, M_READ, 8'h3C, 1'b1, mk(8'h3C, 1'b1, 8'h3C, 1'b1, 40));
        wait_rsp("rd_3c");
        chk("rd_scl_held", 32'(scl_oe), 1);
        chk("rd_sda_released", 32'(sda_oe), 0);
        chk("rd_busy", 32'(busy), 1);

        issue(1'b1, 1'b1, 1'b0, 8'h50, 1'b0, M_NACK, 8'h00, 1'b1, mk(8'h50, 1'b0, 8'h00, 1'b1, 44));
        wait_rsp("wr_50_nack");
        chk("nack_busy", 32'(busy), 0);

        issue(1'b0, 1'b0, 1'b0, 8'h81, 1'b0, M_ACK, 8'h00, 1'b1, mk(8'h81, 1'b0, 8'h00, 1'b0, 40));
        wait_rsp("wr_forced_start");
        chk("forced_busy", 32'(busy), 1);

        issue(1'b0, 1'b1, 1'b0, 8'h0F, 1'b0, M_ACK, 8'h00, 1'b1, mk(8'h0F, 1'b0, 8'h00, 1'b0, 40));
        wait_rsp("wr_no_start_stop");
        chk("nostart_busy", 32'(busy), 0);
        chk("nostart_scl", 32'(scl_oe), 0);

        issue(1'b1, 1'b1, 1'b0, 8'h96, 1'b0, M_ACK, 8'h00, 1'b0, none);
        n = 0;
        while (tcount < 21 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (tcount < 21) begin
            bad++;
            $display("FAIL reset_wait: tick count got %0d expected 21", tcount);
        end
        chk("pre_rst_lines", {30'd0, scl_oe, sda_oe}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_scl_oe", 32'(scl_oe), 0);
        chk("mid_rst_sda_oe", 32'(sda_oe), 0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b1, 1'b1, 1'b0, 8'h33, 1'b0, M_ACK, 8'h00, 1'b1, mk(8'h33, 1'b0, 8'h00, 1'b0, 44));
        wait_rsp("wr_after_rst");

`ifdef I2C_CLK_STRETCH_EN
        stretch_req = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, M_ACK, 8'h00, 1'b1, mk(8'hC3, 1'b0, 8'h00, 1'b0, 54));
        wait_rsp("wr_stretch");
        chk("stretch_done", 32'(st_done), 1);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
